hex_probe_scanner: RTL

Parametrised debug-observation block for the FPGA bring-up harness. It replaces hand-wired fixed probe concatenations feeding the 8-digit hex display with a bus-controlled, multi-channel probe scanner. It samples `CH_COUNT` 16-bit probe channels, freezes them into a snapshot on a trigger, and pages two channels at a time onto a 32-bit nibble bus for the seven-segment decoders. It is a slave on the JTAG-driven 4-register memory bus, alongside the DUT.

---
 rtl/hex_probe_scanner_if.sv | 10 +
 rtl/hex_probe_scanner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_probe_scanner_if.sv
// Control-side bus of the probe scanner: register select, direction and strobe.
// The 16-bit data line is bidirectional, so it stays a plain inout port on the scanner.
interface hex_probe_scanner_if;
    logic [1:0] busAddr;
    logic       busWr;
    logic       busEn;

    modport master (output busAddr, output busWr, output busEn);
    modport slave  (input  busAddr, input  busWr, input  busEn);
endinterface

// File: rtl/hex_probe_scanner.sv
// Multi-channel probe scanner: live/snapshot 16-bit channels paged two at a time onto the hex display.
// Optional trigger-edge counter in STATUS[15:8] is built only when HEXPROBE_TRIGCNT_EN is defined.
module hex_probe_scanner #(
    parameter  int CH_COUNT = 4,
    parameter  int DWELL    = 1000,
    localparam int PAGES    = CH_COUNT / 2,
    localparam int PAGE_W   = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    hex_probe_scanner_if.slave        bus,
    inout  wire  [15:0]               busData,
    input  logic [16*CH_COUNT-1:0]    probeIn,
    input  logic                      trigIn,
    output logic [31:0]               hexOut,
    output logic [PAGE_W-1:0]         pageOut,
    output logic                      armed
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CAPTURED = 2'd2
    } cap_state_e;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CHSEL  = 2'd2;
    localparam logic [1:0] A_DATA   = 2'd3;

    localparam int              DW_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DW_LAST   = DW_W'(DWELL - 1);
    localparam logic [3:0]      LAST_PAGE = 4'(PAGES - 1);

    // ---------------- bus decode ----------------
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        ctrl_wr;
    logic        arm_pulse;
    logic        force_pulse;
    logic        unused_wr_hi;

    assign wr_en        = bus.busEn && bus.busWr;
    assign rd_en        = bus.busEn && !bus.busWr;
    assign wr_data      = busData;
    assign ctrl_wr      = wr_en && (bus.busAddr == A_CTRL);
    assign arm_pulse    = ctrl_wr && wr_data[2];
    assign force_pulse  = ctrl_wr && wr_data[3];
    assign unused_wr_hi = ^wr_data[15:8];

    assign busData = rd_en ? rd_data : 16'hzzzz;

    // ---------------- registers ----------------
    logic              auto_q;
    logic              snap_sel_q;
    logic [3:0]        man_page_q;
    logic [3:0]        ch_sel_q;
    logic              trig_q;
    logic              trig_rise;
    cap_state_e        state_q,  state_d;
    logic              snap_load;
    logic [DW_W-1:0]   dwell_q,  dwell_d;
    logic [PAGE_W-1:0] page_q,   page_d;
    logic [31:0]       hex_q,    hex_d;
    logic [15:0]       snap_q [CH_COUNT];
    logic [15:0]       src_ch [CH_COUNT];
    logic [31:0]       page_word [PAGES];
    logic [7:0]        trig_cnt;

    assign trig_rise = trigIn && !trig_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            auto_q     <= 1'b0;
            snap_sel_q <= 1'b0;
            man_page_q <= 4'd0;
            ch_sel_q   <= 4'd0;
            trig_q     <= 1'b0;
            state_q    <= ST_IDLE;
            dwell_q    <= '0;
            page_q     <= '0;
            hex_q      <= 32'd0;
        end else begin
            if (ctrl_wr) begin
                auto_q     <= wr_data[0];
                snap_sel_q <= wr_data[1];
                man_page_q <= wr_data[7:4];
            end
            if (wr_en && (bus.busAddr == A_CHSEL)) begin
                ch_sel_q <= wr_data[3:0];
            end
            trig_q  <= trigIn;
            state_q <= state_d;
            dwell_q <= dwell_d;
            page_q  <= page_d;
            hex_q   <= hex_d;
        end
    end

    // FORCE beats ARM, and ARM beats a coincident trigger edge.
    always_comb begin
        state_d   = state_q;
        snap_load = 1'b0;
        if (force_pulse) begin
            state_d   = ST_CAPTURED;
            snap_load = 1'b1;
        end else if (arm_pulse) begin
            state_d = ST_ARMED;
        end else if ((state_q == ST_ARMED) && trig_rise) begin
            state_d   = ST_CAPTURED;
            snap_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < CH_COUNT; k++) begin
                snap_q[k] <= 16'd0;
            end
        end else if (snap_load) begin
            for (int k = 0; k < CH_COUNT; k++) begin
                snap_q[k] <= probeIn[16*k +: 16];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH_COUNT; gi++) begin : g_src
            assign src_ch[gi] = snap_sel_q ? snap_q[gi] : probeIn[16*gi +: 16];
        end
        for (gi = 0; gi < PAGES; gi++) begin : g_page
            assign page_word[gi] = {src_ch[2*gi+1], src_ch[2*gi]};
        end
    endgenerate

    // Dwell counter only runs in auto-scan; a manual page is clamped to the last real page.
    always_comb begin
        dwell_d = '0;
        page_d  = page_q;
        if (auto_q) begin
            if (dwell_q == DW_LAST) begin
                page_d = (page_q == PAGE_W'(PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end else begin
            page_d = (man_page_q > LAST_PAGE) ? PAGE_W'(LAST_PAGE) : PAGE_W'(man_page_q);
        end
    end

    // Display word is built from the next page so page and digits change on the same edge.
    always_comb begin
        hex_d = 32'd0;
        for (int p = 0; p < PAGES; p++) begin
            if (page_d == PAGE_W'(p)) begin
                hex_d = page_word[p];
            end
        end
    end

`ifdef HEXPROBE_TRIGCNT_EN
    logic [7:0] trig_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_cnt_q <= 8'd0;
        end else if (arm_pulse) begin
            trig_cnt_q <= 8'd0;
        end else if (trig_rise && (trig_cnt_q != 8'hFF)) begin
            trig_cnt_q <= trig_cnt_q + 8'd1;
        end
    end

    assign trig_cnt = trig_cnt_q;
`else
    assign trig_cnt = 8'h00;
`endif

    // ---------------- register read mux ----------------
    logic [15:0] data_rd;
    logic [2:0]  page_stat;

    assign page_stat = 3'(page_q);

    always_comb begin
        data_rd = 16'd0;
        for (int k = 0; k < CH_COUNT; k++) begin
            if (ch_sel_q == 4'(k)) begin
                data_rd = snap_q[k];
            end
        end
    end

    always_comb begin
        rd_data = 16'd0;
        case (bus.busAddr)
            A_CTRL:   rd_data = {8'h00, man_page_q, 2'b00, snap_sel_q, auto_q};
            A_STATUS: rd_data = {trig_cnt, 1'b0, page_stat, 1'b0, auto_q, state_q};
            A_CHSEL:  rd_data = {12'h000, ch_sel_q};
            A_DATA:   rd_data = data_rd;
            default:  rd_data = 16'd0;
        endcase
    end

    assign hexOut  = hex_q;
    assign pageOut = page_q;
    assign armed   = (state_q == ST_ARMED);

endmodule
